// File: rtl/colscan_pkg.sv
// Shared types and sizing helpers for the multiplexed-matrix column scanner.
package colscan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int DEF_DWELL_CYCLES = 16;
  localparam int DEF_BLANK_CYCLES = 2;

  // The dwell/blank counter only ever reaches max-1, so clog2(max) bits suffice.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/col_next_pick.sv
// Combinational pick of the next enabled column strictly above i_idx, wrapping
// to the lowest enabled column; flags the wrap and an empty mask.
module col_next_pick
  import colscan_pkg::*;
#(
  parameter  int NUM_COLS = 4,
  localparam int IDX_W    = $clog2(NUM_COLS)
) (
  input  logic [NUM_COLS-1:0] i_mask,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [IDX_W-1:0]    o_next,
  output logic                o_wrapped,
  output logic                o_none
);

  logic [IDX_W-1:0] w_above;
  logic [IDX_W-1:0] w_lowest;
  logic             w_found;

  // Descending walk so the last hit is the lowest qualifying column.
  always_comb begin
    w_above  = '0;
    w_lowest = '0;
    w_found  = 1'b0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_lowest = IDX_W'(i);
        if (IDX_W'(i) > i_idx) begin
          w_above = IDX_W'(i);
          w_found = 1'b1;
        end else begin
          w_found = w_found;
        end
      end else begin
        w_found = w_found;
      end
    end
    o_none    = (i_mask == '0);
    o_wrapped = !w_found;
    o_next    = w_found ? w_above : w_lowest;
  end

endmodule

// File: rtl/col_scanner.sv
// One-hot column scanner with per-column dwell, inter-column blanking, runtime
// column mask and frame-start pulse. Define COLSCAN_PWM_EN for per-dwell brightness.
module col_scanner
  import colscan_pkg::*;
#(
  parameter  int NUM_COLS     = 4,
  parameter  int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int IDX_W        = $clog2(NUM_COLS)
`ifdef COLSCAN_PWM_EN
  , localparam int BRIGHT_W   = $clog2(DWELL_CYCLES + 1)
`endif
) (
  input  logic                multiplexClk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_COLS-1:0] colMask,
`ifdef COLSCAN_PWM_EN
  input  logic [BRIGHT_W-1:0] brightness,
`endif
  output logic [NUM_COLS-1:0] colEn,
  output logic [IDX_W-1:0]    colIdx,
  output logic                blanking,
  output logic                frameStart
);

  localparam int               CNT_W      = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(NUM_COLS - 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [IDX_W-1:0]    w_idx_nx;
  logic [IDX_W-1:0]    w_pick_from;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_wrapped;
  logic                w_pick_none;
  logic                w_select;
  logic                w_fs_nx;
  logic [NUM_COLS-1:0] w_colEn_nx;
`ifdef COLSCAN_PWM_EN
  logic [BRIGHT_W-1:0] r_bright;
  logic [BRIGHT_W-1:0] w_bright_nx;
`endif

  // From IDLE, searching above the top index always wraps to the lowest set bit.
  assign w_pick_from = (r_state == IDLE) ? IDX_TOP : colIdx;

  col_next_pick #(
    .NUM_COLS(NUM_COLS)
  ) u_next_pick (
    .i_mask   (colMask),
    .i_idx    (w_pick_from),
    .o_next   (w_pick_idx),
    .o_wrapped(w_pick_wrapped),
    .o_none   (w_pick_none)
  );

  // Next-state, counter and column-selection logic.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = colIdx;
    w_fs_nx    = 1'b0;
    w_select   = 1'b0;
`ifdef COLSCAN_PWM_EN
    w_bright_nx = r_bright;
`endif
    if (!enable) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_select = 1'b1;
        end
        DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            if (BLANK_CYCLES > 0) begin
              w_state_nx = BLANK;
              w_cnt_nx   = '0;
            end else begin
              w_select = 1'b1;
            end
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_select = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end
      endcase
    end

    // The mask is only consulted here; an empty mask parks the scanner.
    if (w_select) begin
      w_cnt_nx = '0;
      if (w_pick_none) begin
        w_state_nx = IDLE;
      end else begin
        w_state_nx = DRIVE;
        w_idx_nx   = w_pick_idx;
        w_fs_nx    = w_pick_wrapped;
`ifdef COLSCAN_PWM_EN
        w_bright_nx = brightness;
`endif
      end
    end else begin
      w_fs_nx = 1'b0;
    end
  end

  // Column drive for the upcoming cycle, gated by the dwell position under PWM.
  always_comb begin
    w_colEn_nx = '0;
    if (w_state_nx == DRIVE) begin
`ifdef COLSCAN_PWM_EN
      w_colEn_nx = (int'(w_cnt_nx) < int'(w_bright_nx)) ? (NUM_COLS'(1) << w_idx_nx) : '0;
`else
      w_colEn_nx = NUM_COLS'(1) << w_idx_nx;
`endif
    end else begin
      w_colEn_nx = '0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge multiplexClk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      colEn      <= '0;
      colIdx     <= '0;
      blanking   <= 1'b0;
      frameStart <= 1'b0;
`ifdef COLSCAN_PWM_EN
      r_bright   <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      colEn      <= w_colEn_nx;
      colIdx     <= w_idx_nx;
      blanking   <= (w_state_nx == BLANK);
      frameStart <= w_fs_nx;
`ifdef COLSCAN_PWM_EN
      r_bright   <= w_bright_nx;
`endif
    end
  end

endmodule
